// File: rtl/timer_bank_pkg.sv
// Shared codes, limits, lap entry type and BCD helpers for timer_bank.
// Used by timer_bank and bcd_time_channel.
package timer_bank_pkg;

    localparam logic [1:0] FIELD_MIN  = 2'b00;
    localparam logic [1:0] FIELD_SEC  = 2'b01;
    localparam logic [1:0] FIELD_MS10 = 2'b10;
    localparam logic [1:0] FIELD_NONE = 2'b11;

    localparam logic [7:0] BCD_MAX_SEC = 8'h59;
    localparam logic [7:0] BCD_MAX_99  = 8'h99;

    localparam logic MODE_STOPWATCH = 1'b0;
    localparam logic MODE_COUNTDOWN = 1'b1;

    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] min;
        logic [7:0] sec;
        logic [7:0] ms_10;
    } lap_entry_t;

    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v,
        input logic [7:0] max
    );
        if (v == max) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(
        input logic [7:0] v,
        input logic [7:0] max
    );
        if (v == 8'h00) return max;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/timer_bank_channel.sv
// One BCD time channel: value, run/mode/time-out state, count step
// and field edit. Commands arrive already gated to this channel.
module bcd_time_channel
    import timer_bank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       clear,
    input  logic       mode_tgl,
    input  logic       start_stop,
    input  logic       up,
    input  logic       down,
    input  logic [1:0] target,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic [7:0] ms_10,
    output logic       running,
    output logic       time_out,
    output logic       mode,
    output logic       zero
);

    logic [7:0] nxt_min;
    logic [7:0] nxt_sec;
    logic [7:0] nxt_ms;
    logic       nxt_zero;
    logic       adj;
    logic [7:0] edit_val;
    logic [7:0] edit_max;
    logic [7:0] edit_res;

    assign zero = (min == 8'h00) && (sec == 8'h00) && (ms_10 == 8'h00);
    assign nxt_zero = ({nxt_min, nxt_sec, nxt_ms} == 24'h0);
    assign adj = (mode == MODE_COUNTDOWN) && (up ^ down)
              && (target != FIELD_NONE);

    always_comb begin
        nxt_min = min;
        nxt_sec = sec;
        nxt_ms  = ms_10;
        if (mode == MODE_STOPWATCH) begin
            nxt_ms = bcd_inc(ms_10, BCD_MAX_99);
            if (ms_10 == BCD_MAX_99) begin
                nxt_sec = bcd_inc(sec, BCD_MAX_SEC);
                if (sec == BCD_MAX_SEC) nxt_min = bcd_inc(min, BCD_MAX_99);
            end
        end else if (!zero) begin
            nxt_ms = bcd_dec(ms_10, BCD_MAX_99);
            if (ms_10 == 8'h00) begin
                nxt_sec = bcd_dec(sec, BCD_MAX_SEC);
                if (sec == 8'h00) nxt_min = bcd_dec(min, BCD_MAX_99);
            end
        end
    end

    always_comb begin
        edit_val = ms_10;
        edit_max = BCD_MAX_99;
        unique case (target)
            FIELD_MIN: edit_val = min;
            FIELD_SEC: begin
                edit_val = sec;
                edit_max = BCD_MAX_SEC;
            end
            default: ;
        endcase
        edit_res = up ? bcd_inc(edit_val, edit_max)
                      : bcd_dec(edit_val, edit_max);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min      <= 8'h00;
            sec      <= 8'h00;
            ms_10    <= 8'h00;
            running  <= 1'b0;
            time_out <= 1'b0;
            mode     <= MODE_STOPWATCH;
        end else if (clear) begin
            min      <= 8'h00;
            sec      <= 8'h00;
            ms_10    <= 8'h00;
            running  <= 1'b0;
            time_out <= 1'b0;
        end else if (mode_tgl && !running) begin
            mode     <= ~mode;
            min      <= 8'h00;
            sec      <= 8'h00;
            ms_10    <= 8'h00;
            time_out <= 1'b0;
        end else if (running) begin
            // a stop on the same edge still takes this tick's step
            if (tick) begin
                min   <= nxt_min;
                sec   <= nxt_sec;
                ms_10 <= nxt_ms;
                if (mode == MODE_COUNTDOWN && nxt_zero) begin
                    running  <= 1'b0;
                    time_out <= 1'b1;
                end
            end
            if (start_stop) running <= 1'b0;
        end else if (start_stop) begin
            if (!(mode == MODE_COUNTDOWN && zero)) begin
                running  <= 1'b1;
                time_out <= 1'b0;
            end
        end else if (adj) begin
            unique case (target)
                FIELD_MIN: min   <= edit_res;
                FIELD_SEC: sec   <= edit_res;
                default:   ms_10 <= edit_res;
            endcase
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Multi-channel BCD stopwatch/countdown bank with shared lap FIFO.
// Lap FIFO is built only when TIMER_BANK_LAP_EN is defined.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int LAP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick_i,
    input  logic [CW-1:0]              sel_i,
    input  logic                       start_stop_i,
    input  logic                       clear_i,
    input  logic                       lap_i,
    input  logic                       mode_i,
    input  logic                       field_i,
    input  logic                       up_i,
    input  logic                       down_i,
    input  logic                       lap_rd_i,
    output logic [7:0]                 min_o,
    output logic [7:0]                 sec_o,
    output logic [7:0]                 ms_10_o,
    output logic [1:0]                 target_o,
    output logic [CHANNELS-1:0]        running_o,
    output logic [CHANNELS-1:0]        time_out_o,
    output logic [CHANNELS-1:0]        mode_o,
    output logic [7:0]                 lap_min_o,
    output logic [7:0]                 lap_sec_o,
    output logic [7:0]                 lap_ms_10_o,
    output logic [CW-1:0]              lap_ch_o,
    output logic [$clog2(LAP_DEPTH):0] lap_count_o,
    output logic                       lap_ovf_o
);

    logic [CW-1:0]       sel_q;
    logic [CW-1:0]       sel_eff;
    logic [1:0]          target_q;
    logic [7:0]          ch_min [CHANNELS];
    logic [7:0]          ch_sec [CHANNELS];
    logic [7:0]          ch_ms  [CHANNELS];
    logic [CHANNELS-1:0] ch_zero;
    logic                s_run;
    logic                s_mode;
    logic                s_zero;
    logic                mode_go;
    logic                start_go;
    logic                field_go;

    // out-of-range selections keep the previous channel
    assign sel_eff = (int'(sel_i) < CHANNELS) ? sel_i : sel_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic hit;
        assign hit = (int'(sel_eff) == i);
        bcd_time_channel u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick_i),
            .clear      (clear_i & hit),
            .mode_tgl   (mode_i & hit),
            .start_stop (start_stop_i & hit),
            .up         (up_i & hit),
            .down       (down_i & hit),
            .target     (target_q),
            .min        (ch_min[i]),
            .sec        (ch_sec[i]),
            .ms_10      (ch_ms[i]),
            .running    (running_o[i]),
            .time_out   (time_out_o[i]),
            .mode       (mode_o[i]),
            .zero       (ch_zero[i])
        );
    end

    assign s_run  = running_o[sel_eff];
    assign s_mode = mode_o[sel_eff];
    assign s_zero = ch_zero[sel_eff];

    assign mode_go  = !clear_i && mode_i && !s_run;
    assign start_go = !clear_i && !mode_go && start_stop_i && !s_run
                   && !(s_mode == MODE_COUNTDOWN && s_zero);
    assign field_go = !clear_i && !mode_go && !start_stop_i && field_i
                   && (s_mode == MODE_COUNTDOWN) && !s_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            target_q <= FIELD_NONE;
        end else begin
            sel_q <= sel_eff;
            if ((sel_eff != sel_q) || mode_go || start_go) begin
                target_q <= FIELD_NONE;
            end else if (field_go) begin
                target_q <= target_q + 2'd1;
            end
        end
    end

    assign target_o = target_q;
    assign min_o    = ch_min[sel_q];
    assign sec_o    = ch_sec[sel_q];
    assign ms_10_o  = ch_ms[sel_q];

`ifdef TIMER_BANK_LAP_EN
    localparam int AW = $clog2(LAP_DEPTH);

    lap_entry_t    lap_mem [LAP_DEPTH];
    lap_entry_t    push_entry;
    lap_entry_t    head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   lap_cnt;
    logic          lap_ovf;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic [7:0]    unused_ch_hi;

    assign full    = (lap_cnt == (AW+1)'(LAP_DEPTH));
    assign pop     = lap_rd_i && (lap_cnt != '0);
    assign push    = lap_i && (s_mode == MODE_STOPWATCH);
    assign push_ok = push && (!full || pop);

    always_comb begin
        push_entry = '0;
        push_entry.ch[CW-1:0] = sel_eff;
        push_entry.min   = ch_min[sel_eff];
        push_entry.sec   = ch_sec[sel_eff];
        push_entry.ms_10 = ch_ms[sel_eff];
    end

    always_ff @(posedge clk) begin
        if (push_ok) lap_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            lap_cnt <= '0;
            lap_ovf <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop) begin
                lap_cnt <= lap_cnt + (AW+1)'(1);
            end else if (pop && !push_ok) begin
                lap_cnt <= lap_cnt - (AW+1)'(1);
            end
            if (push && !push_ok) lap_ovf <= 1'b1;
        end
    end

    assign head         = (lap_cnt == '0) ? '0 : lap_mem[rd_ptr];
    assign unused_ch_hi = head.ch;
    assign lap_min_o    = head.min;
    assign lap_sec_o    = head.sec;
    assign lap_ms_10_o  = head.ms_10;
    assign lap_ch_o     = head.ch[CW-1:0];
    assign lap_count_o  = lap_cnt;
    assign lap_ovf_o    = lap_ovf;
`else
    logic unused_lap;

    assign unused_lap  = ^{lap_i, lap_rd_i};
    assign lap_min_o   = '0;
    assign lap_sec_o   = '0;
    assign lap_ms_10_o = '0;
    assign lap_ch_o    = '0;
    assign lap_count_o = '0;
    assign lap_ovf_o   = 1'b0;
`endif

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel time core replacing the single stopwatch/single countdown pair: CHANNELS independent BCD channels, each in stopwatch or countdown mode, plus a shared lap-record FIFO. Sits between the button debouncers and the display blocks; it consumes the 100 Hz strobe and debounced one-cycle button pulses and drives min/sec/ms_10 BCD, flicker target and time-out to the seven-segment, LED and VGA blocks.

## Interface
- CHANNELS, 2: number of time channels, ≥1.
- CW, $clog2(CHANNELS) (min 1): channel index width.
- LAP_DEPTH, 4: lap FIFO entries, power of two, ≥2.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous and active-high.
- tick_i  in  1  one-cycle 100 Hz strobe in the clk domain.
- sel_i  in  CW  channel that receives commands and drives display outputs; values ≥CHANNELS ignored (hold previous selection).
- start_stop_i, clear_i, lap_i, mode_i, field_i, up_i, down_i  in  1 each  one-cycle command pulses.
- lap_rd_i  in  1  pop lap FIFO head.
- min_o, sec_o, ms_10_o  out  8 each  BCD time of selected channel.
- target_o  out  2  edit field: 00 min, 01 sec, 10 ms_10, 11 none.
- running_o, time_out_o, mode_o  out  CHANNELS each  per-channel run, sticky time-out, mode (0 stopwatch, 1 countdown).
- lap_min_o, lap_sec_o, lap_ms_10_o  out  8 each  FIFO head; zero when empty.
- lap_ch_o  out  CW  channel of head entry.
- lap_count_o  out  $clog2(LAP_DEPTH)+1  occupancy.
- lap_ovf_o  out  1  sticky: lap dropped on full.

## Operation
- Ranges: ms_10 00–99, sec 00–59, min 00–99, all BCD.
- tick_i advances every running channel; commands act on selected channel only.
- Stopwatch: +1 ms_10 per tick with carry; 99:59.99 wraps to 00:00.00, keeps running.
- Countdown: −1 per tick with borrow; tick at 00:00.01 gives 00:00.00, clears running, sets time_out same edge.
- start_stop: toggles running. Countdown at 00:00.00 ignores start. Any start clears time_out.
- clear: value 00:00.00, running 0, time_out 0.
- mode: only when stopped; toggles mode, clears value and time_out. Ignored while running.
- field: countdown and stopped only; target cycles 11→00→01→10→11. Otherwise ignored.
- up/down: countdown, stopped, target≠11: ±1 on target field, wrapping within its range, no carry to other fields.
- target forced to 11 on start, on mode change, on sel_i change, and whenever selected channel is stopwatch.
- lap: stopwatch channel only (running or stopped); pushes {sel, current value} to FIFO. Countdown lap ignored.
- FIFO full + lap: entry dropped, lap_ovf_o set; cleared only by rst. lap_rd_i on empty ignored. Push and pop same cycle when full: both performed, no overflow.
- Priority per channel in one cycle: rst > clear > mode > start_stop > field/up/down; up+down together ignored. lap independent of these.

## Timing
- Reset: all values 00:00.00, running 0, time_out 0, mode 0, target 11, sel 0, FIFO empty, lap_count 0, lap_ovf 0; all outputs zero except target_o=11.
- State registered; display outputs are combinational mux of registered state: effect of a pulse sampled at edge k visible right after edge k.
- Tick and command same edge: count step uses pre-edge running; lap captures pre-edge value; clear wins over tick.
- FIFO first-word-fall-through; pushed entry visible at head one edge after push when previously empty.
- rst mid-count or mid-edit returns to reset state at the next edge.

## Configuration
- TIMER_BANK_LAP_EN defined: lap FIFO built as above.
- Undefined: no FIFO storage; lap_i and lap_rd_i ignored; lap_* outputs, lap_count_o and lap_ovf_o tied to 0.

## Structure
- Package timer_bank_pkg: field codes FIELD_MIN/SEC/MS10/NONE, BCD limits (59, 99), lap entry struct {ch, min, sec, ms_10}, mode codes.
- Sub-module bcd_time_channel: one channel's BCD value, run/mode/time_out, inc/dec/adjust; instantiated CHANNELS times. FIFO and target logic stay in timer_bank.

## Test plan
- Stopwatch ch0 start, 100 ticks → 00:01.00; preload 99:59.99 + tick → 00:00.00, running_o[0]=1.
- Countdown ch1: mode, field×2 (target 01), up×3 → 00:03.00; start, 300 ticks → 00:00.00, running_o[1]=0, time_out_o[1]=1.
- Countdown edit wrap: sec target, down at 00 → 59; field while running → target stays 11.
- Laps at 00:00.05 and 00:00.10 → lap_count 2, head 00:00.05 ch0; lap_rd → head 00:00.10.
- LAP_DEPTH+1 laps → count LAP_DEPTH, lap_ovf_o=1; rd on empty → count 0 unchanged.
- clear and tick same edge on running channel → 00:00.00, stopped; rst mid-countdown → all reset values.
